// File: rtl/score_bcd_keeper.sv
// score_bcd_keeper
// Saturating two-digit BCD score keeper with scan strobe generation.
// Shot events of 1-3 points are added one unit per clock so that the
// BCD carry only ever ripples from d0 into d1. A free-running divider
// produces the scan_en strobe for the downstream digit multiplexer.
module score_bcd_keeper #(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned SCAN_HZ   = 4000,
    parameter int unsigned MAX_SCORE = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       shot_valid,
    input  logic [1:0] shot_pts,
    output logic       shot_ready,
    output logic       saturated,
    output logic       scan_en,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0
);

    localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [3:0]    MAX_TENS = 4'(MAX_SCORE / 10);
    localparam logic [3:0]    MAX_ONES = 4'(MAX_SCORE % 10);

    typedef enum logic {
        IDLE,
        ADD
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_scan_en;
    logic [3:0]    r_d1;
    logic [3:0]    r_d0;
    logic [1:0]    r_rem;
    logic          r_sat;
    logic          w_at_max;
    logic          w_accept;

    assign w_at_max = (r_d1 == MAX_TENS) && (r_d0 == MAX_ONES);
    assign w_accept = shot_valid && (shot_pts != 2'd0);

    // Scan divider: counts 0..DIV-1, strobe registered one cycle after the wrap value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_scan_en <= 1'b0;
        end else begin
            r_scan_en <= (r_cnt == CNT_LAST);
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // FSM state register; clear forces IDLE from any state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else if (clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state: leave ADD on saturation or after the last unit
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = ADD;
                end
            end
            ADD: begin
                if (w_at_max || (r_rem == 2'd1)) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs: events are accepted only while idle
    always_comb begin
        shot_ready = 1'b0;
        if (r_state == IDLE) begin
            shot_ready = 1'b1;
        end
    end

    // Score datapath: latch points on accept, add one unit per ADD cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d1  <= '0;
            r_d0  <= '0;
            r_rem <= '0;
            r_sat <= 1'b0;
        end else if (clear) begin
            r_d1  <= '0;
            r_d0  <= '0;
            r_rem <= '0;
            r_sat <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rem <= shot_pts;
                    end
                end
                ADD: begin
                    if (w_at_max) begin
                        r_sat <= 1'b1;
                        r_rem <= '0;
                    end else begin
                        if (r_d0 == 4'd9) begin
                            r_d0 <= '0;
                            r_d1 <= r_d1 + 4'd1;
                        end else begin
                            r_d0 <= r_d0 + 4'd1;
                        end
                        r_rem <= r_rem - 2'd1;
                    end
                end
                default: r_rem <= '0;
            endcase
        end
    end

    assign saturated = r_sat;
    assign scan_en   = r_scan_en;
    assign d3        = 4'hF;
    assign d2        = 4'hF;
    assign d1        = r_d1;
    assign d0        = r_d0;

endmodule

// File: tb/tb_score_bcd_keeper.sv
// tb_score_bcd_keeper
// Scoreboard bench: the driver updates an integer score model at every
// clock edge and queues the expected outputs; a monitor on the falling
// edge pops and compares against the DUT.
module tb_score_bcd_keeper;

    localparam int unsigned CLK_HZ  = 40;
    localparam int unsigned SCAN_HZ = 4;
    localparam int unsigned DIV     = CLK_HZ / SCAN_HZ;
    localparam int          MAXS    = 99;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       shot_valid;
    logic [1:0] shot_pts;
    logic       shot_ready;
    logic       saturated;
    logic       scan_en;
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;

    score_bcd_keeper #(
        .CLK_HZ   (CLK_HZ),
        .SCAN_HZ  (SCAN_HZ),
        .MAX_SCORE(MAXS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .shot_valid(shot_valid),
        .shot_pts  (shot_pts),
        .shot_ready(shot_ready),
        .saturated (saturated),
        .scan_en   (scan_en),
        .d3        (d3),
        .d2        (d2),
        .d1        (d1),
        .d0        (d0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   score;
        logic sat;
        logic rdy;
        logic scan;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int   m_score;
    int   m_pend;
    logic m_sat;
    int   m_cyc;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Pending points drain one per edge; at 99 the remainder is discarded
    task automatic model_edge(input logic c, input logic v, input logic [1:0] p);
        m_cyc++;
        if (c) begin
            m_score = 0;
            m_pend  = 0;
            m_sat   = 1'b0;
        end else if (m_pend > 0) begin
            if (m_score >= MAXS) begin
                m_sat  = 1'b1;
                m_pend = 0;
            end else begin
                m_score++;
                m_pend--;
            end
        end else if (v && p != 0) begin
            m_pend = int'(p);
        end
    endtask

    task automatic step(input logic c, input logic v, input logic [1:0] p);
        exp_t e;
        clear      = c;
        shot_valid = v;
        shot_pts   = p;
        @(posedge clk);
        model_edge(c, v, p);
        e.score = m_score;
        e.sat   = m_sat;
        e.rdy   = (m_pend == 0);
        e.scan  = (m_cyc > 0) && (m_cyc % DIV == 0);
        q.push_back(e);
        #1;
    endtask

    task automatic shot(input logic [1:0] p);
        step(1'b0, 1'b1, p);
        for (int k = 0; k < 6 && m_pend > 0; k++) step(1'b0, 1'b0, 2'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_d1"}, int'(d1), 0);
        check({tag, "_d0"}, int'(d0), 0);
        check({tag, "_ready"}, int'(shot_ready), 1);
        check({tag, "_sat"}, int'(saturated), 0);
        check({tag, "_scan"}, int'(scan_en), 0);
    endtask

    task automatic model_reset();
        m_score = 0;
        m_pend  = 0;
        m_sat   = 1'b0;
        m_cyc   = 0;
        q.delete();
    endtask

    // Monitor: compare every queued expectation on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            while (q.size() > 0) begin
                e = q.pop_front();
                check("d1", int'(d1), e.score / 10);
                check("d0", int'(d0), e.score % 10);
                check("saturated", int'(saturated), int'(e.sat));
                check("shot_ready", int'(shot_ready), int'(e.rdy));
                check("scan_en", int'(scan_en), int'(e.scan));
                check("blank", int'({d3, d2}), 8'hFF);
            end
        end
    end

    initial begin
        rst        = 1'b0;
        clear      = 1'b0;
        shot_valid = 1'b0;
        shot_pts   = 2'd0;
        model_reset();
        #12;
        check_reset_state("reset");
        @(negedge clk);
        #1 rst = 1'b1;

        // idle cycles cover the first scan strobes at 10, 20, 30
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 2'd0);

        // build 08 then add 3 across the BCD carry
        shot(2'd3);
        shot(2'd3);
        shot(2'd2);
        shot(2'd3);

        // zero-point event ignored; events during ADD ignored
        step(1'b0, 1'b1, 2'd0);
        step(1'b0, 1'b1, 2'd3);
        step(1'b0, 1'b1, 2'd2);
        step(1'b0, 1'b1, 2'd1);
        step(1'b0, 1'b1, 2'd2);
        step(1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 2'd0);
        for (int k = 0; k < 6 && m_pend > 0; k++) step(1'b0, 1'b0, 2'd0);

        // clear on the second ADD cycle of a 3-point shot from 20
        step(1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 6; i++) shot(2'd3);
        shot(2'd2);
        step(1'b0, 1'b1, 2'd3);
        step(1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b1, 2'd2);
        step(1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 2'd0);

        // saturation from 98
        for (int i = 0; i < 32; i++) shot(2'd3);
        shot(2'd2);
        shot(2'd3);
        shot(2'd2);
        step(1'b0, 1'b0, 2'd0);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 59) == 0), 1'(($urandom_range(0, 1))),
                 2'($urandom_range(0, 3)));
        end

        // asynchronous reset mid-ADD
        shot(2'd3);
        step(1'b0, 1'b1, 2'd3);
        step(1'b0, 1'b0, 2'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_state("async_rst");
        model_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 2'd0);
        shot(2'd1);
        step(1'b0, 1'b0, 2'd0);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/score_bcd_keeper.md
Name: score_bcd_keeper

Overview:
- Upstream feeder for the two-digit seven-segment multiplexer.
- Accepts "shot made" events carrying a point value (1-3) and keeps a saturating 0-99 score as two BCD digits.
- Adds points one unit per clock, so BCD carry stays trivial.
- Generates the periodic scan_en strobe that the multiplexer uses to alternate digits.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- SCAN_HZ, 4000, scan_en strobe rate in Hz. Divider DIV = CLK_HZ/SCAN_HZ (integer), must be >= 2.
- MAX_SCORE, 99, saturation value. Fixed two-digit BCD; legal range 1-99.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset (0 = reset)
- clear  input  1  synchronous score clear, active-high
- shot_valid  input  1  shot event present
- shot_pts  input  2  points for the event (0-3)
- shot_ready  output  1  block can accept an event this cycle
- saturated  output  1  sticky: points were discarded at MAX_SCORE
- scan_en  output  1  one-cycle strobe at SCAN_HZ
- d3  output  4  constant 4'hF (blank)
- d2  output  4  constant 4'hF (blank)
- d1  output  4  tens digit, BCD 0-9
- d0  output  4  ones digit, BCD 0-9

Behaviour:
- Reset (rst=0, asynchronous):
  - d1=d0=0, saturated=0, scan_en=0, shot_ready=1 (FSM IDLE).
  - Scan counter=0, remaining=0.
  - Outputs hold their reset values until the first clk edge after rst deasserts.
- Scan divider:
  - Counter runs 0..DIV-1 and wraps to 0.
  - scan_en is registered and is 1 exactly in the cycle after the counter equals DIV-1, giving period DIV cycles.
  - First strobe is at cycle DIV after reset release.
  - clear has no effect on the divider.
- FSM states: IDLE, ADD.
- IDLE:
  - shot_ready=1.
  - On shot_valid=1 with shot_pts!=0: latch remaining=shot_pts and go to ADD.
  - On shot_valid=1 with shot_pts=0: ignore and stay in IDLE.
- ADD:
  - shot_ready=0. shot_valid is ignored (not queued).
  - Each cycle, if score==MAX_SCORE: set saturated=1, remaining=0, go to IDLE.
  - Otherwise increment the score:
    - If d0==9: d0=0, d1=d1+1.
    - Else: d0=d0+1.
    - remaining = remaining-1.
    - If remaining was 1, go to IDLE.
- Latency: an accepted N-point event updates the digits on N consecutive edges. shot_ready returns to 1 the cycle after the last increment.
- Back-to-back events: a new event may be accepted in the first IDLE cycle. Minimum spacing is N+1 cycles.
- Digits never exceed BCD 9 and the score never exceeds MAX_SCORE.
- saturated is sticky until clear or reset.
- clear=1 (synchronous, highest priority, any state):
  - d1=d0=0, saturated=0, remaining=0, FSM to IDLE.
  - An event presented in the same cycle is dropped.
- Reset during ADD aborts the addition immediately. Partial points are lost.
- d3/d2 are constant 4'hF so unused display positions decode to blank.

Test Plan:
1. Reset release with CLK_HZ=40, SCAN_HZ=4 (DIV=10) -> d1:d0=00, shot_ready=1, saturated=0; scan_en pulses 1 cycle wide at cycles 10, 20, 30 after release.
2. From score 08, apply shot_pts=3 for one cycle -> shot_ready=0 for 3 cycles; d1:d0 goes 09, 10, 11 on successive edges; shot_ready=1 on the 4th cycle.
3. From score 98, apply shot_pts=3 -> 99 after 1 edge; next edge saturated=1 and FSM returns to IDLE; score stays 99. A further 2-point shot leaves 99 with saturated still 1.
4. shot_pts=0 with shot_valid=1 -> no state change, shot_ready stays 1. shot_valid asserted during ADD -> ignored, final score reflects the first event only.
5. clear asserted on the 2nd cycle of a 3-point ADD from 20 -> next cycle 00, FSM IDLE, saturated=0. scan_en cadence is unaffected.
6. rst driven low asynchronously mid-ADD (between edges) -> d1:d0=00 and shot_ready=1 immediately without a clock edge.
